// File: rtl/inst_queue_pkg.sv
// Shared sizing and payload types for the fetch-to-decode instruction queue.
package inst_queue_pkg;

    localparam int unsigned IQ_DEPTH = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_pkt_t;

endpackage

// File: rtl/inst_queue.sv
// Circular fetch-to-decode instruction queue with valid/ready on both sides and one-cycle flush.
// Optional zero-latency empty-queue bypass: define INST_QUEUE_BYPASS_EN.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      backend_flush,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [31:0]               enq_pc,
    input  logic [31:0]               enq_inst,
    output logic                      deq_valid,
    input  logic                      deq_ready,
    output logic [31:0]               deq_pc,
    output logic [31:0]               deq_inst,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W:0] ptr_t;

    fetch_pkt_t mem [DEPTH];
    ptr_t       head;
    ptr_t       tail;

    logic       empty_c;
    logic       full_c;
    logic       do_enq_c;
    logic       do_deq_c;
    fetch_pkt_t enq_pkt_c;
    fetch_pkt_t head_pkt_c;
    fetch_pkt_t deq_pkt_c;

    // Wrap bit (MSB) distinguishes full from empty when the indices match.
    assign empty_c    = (head == tail);
    assign full_c     = (head[PTR_W-1:0] == tail[PTR_W-1:0]) && (head[PTR_W] != tail[PTR_W]);
    assign enq_ready  = !full_c;
    assign count      = tail - head;
    assign enq_pkt_c  = '{pc: enq_pc, inst: enq_inst};
    assign head_pkt_c = mem[head[PTR_W-1:0]];
    assign deq_pc     = deq_pkt_c.pc;
    assign deq_inst   = deq_pkt_c.inst;

    // Handshake resolution; a flush kills whatever fires in the same cycle.
    always_comb begin
        deq_valid = !empty_c;
        deq_pkt_c = head_pkt_c;
        do_enq_c  = enq_valid && !full_c && !backend_flush;
        do_deq_c  = !empty_c && deq_ready && !backend_flush;
`ifdef INST_QUEUE_BYPASS_EN
        if (empty_c && enq_valid && !backend_flush) begin
            deq_valid = 1'b1;
            deq_pkt_c = enq_pkt_c;
            if (deq_ready) begin
                do_enq_c = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || backend_flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (do_enq_c) begin
                tail <= tail + ptr_t'(1);
            end
            if (do_deq_c) begin
                head <= head + ptr_t'(1);
            end
        end
    end

    // Storage is intentionally not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (!rst && do_enq_c) begin
            mem[tail[PTR_W-1:0]] <= enq_pkt_c;
        end
    end

endmodule
